// File: rtl/ucie_pattern_pkg.sv
// Shared definitions for the mainband training pattern generator and comparator:
// state encodings, LFSR polynomial constants, per-lane seed and lane ID helpers.
package ucie_pattern_pkg;

  localparam logic [1:0] ST_IDLE         = 2'b00;
  localparam logic [1:0] ST_CLEAR_LFSR   = 2'b01;
  localparam logic [1:0] ST_PATTERN_LFSR = 2'b10;
  localparam logic [1:0] ST_PER_LANE_IDE = 2'b11;

  localparam int          LFSR_WIDTH     = 23;
  localparam int          SEED_LANE_SHIFT = 19;
  // x^23+x^21+x^16+x^8+x^5+x^2+1 as taps on s[22], s[20], s[15], s[7], s[4], s[1]
  localparam logic [22:0] LFSR_TAP_MASK  = 23'h508092;
  localparam logic [3:0]  ID_NIBBLE      = 4'hA;

  function automatic logic [22:0] lfsr_seed(input logic [22:0] base, input int unsigned lane);
    logic [22:0] lane_bits;
    lane_bits = 23'(lane);
    return base ^ (lane_bits << SEED_LANE_SHIFT);
  endfunction

  function automatic logic [22:0] lfsr_next(input logic [22:0] s);
    logic fb;
    fb = ^(s & LFSR_TAP_MASK);
    return {s[21:0], fb};
  endfunction

  function automatic logic [15:0] lane_id(input int unsigned lane);
    return {ID_NIBBLE, 8'(lane), ID_NIBBLE};
  endfunction

endpackage

// File: rtl/lane_lfsr23.sv
// One lane's 23-bit Fibonacci LFSR; reloads its seed on load, advances on step,
// and presents the current MSB as the stream bit.
module lane_lfsr23
  import ucie_pattern_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [22:0] seed,
  input  logic        load,
  input  logic        step,
  output logic        lfsr_bit
);

  logic [22:0] state_r;

  // LFSR state: seed on reset or load, advance on step, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= seed;
    end else if (load) begin
      state_r <= seed;
    end else if (step) begin
      state_r <= lfsr_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign lfsr_bit = state_r[LFSR_WIDTH-1];

endmodule

// File: rtl/pattern_generator.sv
// Transmit-side training pattern source: per-lane LFSR or repeating lane-ID
// streams with a valid/ready handshake, burst length limit and error injection.
module pattern_generator
  import ucie_pattern_pkg::*;
#(
  parameter int          NUM_LANES      = 16,
  parameter int          LFSR_BEATS     = 4096,
  parameter int          ID_REPEATS     = 128,
  parameter logic [22:0] LFSR_SEED_BASE = 23'h1DBFBC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           i_state,
  input  logic                 i_enable,
  input  logic                 i_ready,
  input  logic [NUM_LANES-1:0] i_inject_err,
  output logic [NUM_LANES-1:0] o_pattern,
  output logic                 o_valid,
  output logic                 o_done
);

  localparam int ID_BEATS  = 16 * ID_REPEATS;
  localparam int MAX_BEATS = (LFSR_BEATS > ID_BEATS) ? LFSR_BEATS : ID_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  logic [1:0]           prev_state_r;
  logic [CNT_W-1:0]     beat_cnt_r;
  logic [3:0]           id_idx_r;
  logic [CNT_W-1:0]     limit_s;
  logic                 mode_entry_s;
  logic                 active_s;
  logic                 load_s;
  logic                 accept_s;
  logic                 lfsr_load_s;
  logic                 lfsr_step_s;
  logic [NUM_LANES-1:0] lfsr_bit_s;
  logic [NUM_LANES-1:0] id_bit_s;
  logic [NUM_LANES-1:0] src_bit_s;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam logic [22:0] LANE_SEED = lfsr_seed(LFSR_SEED_BASE, g);
    localparam logic [15:0] LANE_ID   = lane_id(g);

    lane_lfsr23 u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .seed     (LANE_SEED),
      .load     (lfsr_load_s),
      .step     (lfsr_step_s),
      .lfsr_bit (lfsr_bit_s[g])
    );

    assign id_bit_s[g] = LANE_ID[id_idx_r];
  end

  // Mode entry detection, burst limit, load/accept qualification and source select
  always_comb begin
    mode_entry_s = (i_state != prev_state_r);
    active_s     = (i_state == ST_PATTERN_LFSR) || (i_state == ST_PER_LANE_IDE);
    case (i_state)
      ST_PATTERN_LFSR: limit_s = CNT_W'(LFSR_BEATS);
      ST_PER_LANE_IDE: limit_s = CNT_W'(ID_BEATS);
      default:         limit_s = {CNT_W{1'b0}};
    endcase
    // A mode entry discards the in-flight beat, so nothing loads in that cycle
    load_s      = active_s && !mode_entry_s && (!o_valid || i_ready) && i_enable &&
                  !o_done && (beat_cnt_r < limit_s);
    accept_s    = o_valid && i_ready;
    lfsr_load_s = (i_state == ST_CLEAR_LFSR);
    lfsr_step_s = load_s && (i_state == ST_PATTERN_LFSR);
    case (i_state)
      ST_PER_LANE_IDE: src_bit_s = id_bit_s;
      default:         src_bit_s = lfsr_bit_s;
    endcase
  end

  // Output beat register, burst counters and mode tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state_r <= ST_IDLE;
      beat_cnt_r   <= {CNT_W{1'b0}};
      id_idx_r     <= 4'd0;
      o_pattern    <= {NUM_LANES{1'b0}};
      o_valid      <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      prev_state_r <= i_state;
      if (mode_entry_s) begin
        beat_cnt_r <= {CNT_W{1'b0}};
        id_idx_r   <= 4'd0;
        o_pattern  <= {NUM_LANES{1'b0}};
        o_valid    <= 1'b0;
        o_done     <= 1'b0;
      end else begin
        case (i_state)
          ST_IDLE: begin
            o_pattern <= {NUM_LANES{1'b0}};
            o_valid   <= 1'b0;
          end
          ST_CLEAR_LFSR: begin
            o_pattern <= {NUM_LANES{1'b0}};
            o_valid   <= 1'b0;
            o_done    <= 1'b0;
          end
          ST_PATTERN_LFSR, ST_PER_LANE_IDE: begin
            if (load_s) begin
              o_pattern  <= src_bit_s ^ i_inject_err;
              o_valid    <= 1'b1;
              beat_cnt_r <= beat_cnt_r + CNT_W'(1);
              if (i_state == ST_PER_LANE_IDE) begin
                id_idx_r <= id_idx_r + 4'd1;
              end
            end else if (accept_s) begin
              o_valid <= 1'b0;
              if (beat_cnt_r == limit_s) begin
                o_done <= 1'b1;
              end
            end
          end
          default: begin
            o_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Scoreboard bench for pattern_generator: an independent software model pushes
// expected beats per burst and each accepted DUT beat is popped and compared.
module tb_pattern_generator;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_CLEAR = 2'b01;
  localparam logic [1:0] S_LFSR  = 2'b10;
  localparam logic [1:0] S_IDE   = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  i_state;
  logic        i_enable;
  logic        i_ready;
  logic [15:0] i_inject_err;
  logic [15:0] o_pattern;
  logic        o_valid;
  logic        o_done;

  int tests = 0;
  int fails = 0;
  int burst_acc = 0;

  logic [22:0] m_lfsr [16];
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  pattern_generator #(
    .NUM_LANES      (16),
    .LFSR_BEATS     (4096),
    .ID_REPEATS     (128),
    .LFSR_SEED_BASE (23'h1DBFBC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_state      (i_state),
    .i_enable     (i_enable),
    .i_ready      (i_ready),
    .i_inject_err (i_inject_err),
    .o_pattern    (o_pattern),
    .o_valid      (o_valid),
    .o_done       (o_done)
  );

  function automatic logic [22:0] m_step(input logic [22:0] s);
    logic fb;
    fb = s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1];
    return {s[21:0], fb};
  endfunction

  function automatic logic [22:0] m_seed(input int lane);
    logic [22:0] l;
    l = 23'(lane);
    return 23'h1DBFBC ^ (l << 19);
  endfunction

  task automatic m_reseed();
    for (int i = 0; i < 16; i++) m_lfsr[i] = m_seed(i);
  endtask

  task automatic push_lfsr(input int n);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 16; i++) w[i] = m_lfsr[i][22];
      sb.push_back(w);
      for (int i = 0; i < 16; i++) m_lfsr[i] = m_step(m_lfsr[i]);
    end
  endtask

  task automatic push_ide(input int n);
    logic [15:0] w;
    logic [15:0] id;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 16; i++) begin
        id   = {4'hA, 8'(i), 4'hA};
        w[i] = id[k % 16];
      end
      sb.push_back(w);
    end
  endtask

  // Drives i_ready / i_inject_err each cycle and scores every accepted beat
  task automatic pump(input int n_accept, input int stall_pct, input int inject_at,
                      input bit drop_enable, input int max_cycles);
    int          acc;
    int          cyc;
    bit          stalled;
    logic [15:0] held;
    logic [15:0] exp_w;
    acc = 0; cyc = 0; stalled = 1'b0; held = 16'h0000;
    while (acc < n_accept && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      if (stalled && o_valid) begin
        tests++;
        if (o_pattern !== held) begin
          fails++;
          $display("FAIL stall_hold: o_pattern=%h required %h", o_pattern, held);
        end
      end
      i_ready = (int'($urandom_range(99, 0)) >= stall_pct) ? 1'b1 : 1'b0;
      i_inject_err = ((!o_valid || i_ready) && (burst_acc + int'(o_valid) == inject_at)) ?
                     16'h0081 : 16'h0000;
      if (o_valid && i_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: o_pattern=%h with empty scoreboard", o_pattern);
        end else begin
          exp_w = sb.pop_front();
          if (o_pattern !== exp_w) begin
            fails++;
            $display("FAIL beat_%0d: o_pattern=%h required %h", burst_acc, o_pattern, exp_w);
          end
        end
        acc++;
        burst_acc++;
        stalled = 1'b0;
        if (drop_enable && acc == n_accept) i_enable = 1'b0;
      end else begin
        stalled = o_valid;
        held    = o_pattern;
      end
    end
    tests++;
    if (acc < n_accept) begin
      fails++;
      $display("FAIL pump_timeout: accepted %0d beats, required %0d", acc, n_accept);
    end
    i_inject_err = 16'h0000;
  endtask

  task automatic do_clear();
    @(negedge clk);
    i_state = S_CLEAR;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_done_end(input string name);
    bit stayed_low;
    @(negedge clk);
    tests++;
    if (o_done !== 1'b1 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: o_done=%b o_valid=%b required 1 0", name, o_done, o_valid);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_count: %0d expected beats never produced, required 0", name, sb.size());
    end
    stayed_low = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (o_valid !== 1'b0 || o_done !== 1'b1) stayed_low = 1'b0;
    end
    tests++;
    if (!stayed_low) begin
      fails++;
      $display("FAIL %s_sticky: o_valid=%b o_done=%b required 0 1", name, o_valid, o_done);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (o_valid !== 1'b0 || o_done !== 1'b0 || o_pattern !== 16'h0000) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b done=%b pattern=%h required 0 0 0000",
               o_valid, o_done, o_pattern);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (o_valid !== 1'b0 || o_pattern !== 16'h0000) begin
      fails++;
      $display("FAIL idle_outputs: valid=%b pattern=%h required 0 0000", o_valid, o_pattern);
    end
  endtask

  task automatic test_lfsr_burst();
    do_clear();
    m_reseed();
    sb.delete();
    push_lfsr(4096);
    burst_acc = 0;
    i_ready = 1'b0;
    i_enable = 1'b1;
    i_state = S_LFSR;
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL entry_cycle_valid: o_valid=%b required 0", o_valid);
    end
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b1) begin
      fails++;
      $display("FAIL first_beat_latency: o_valid=%b required 1", o_valid);
    end
    tests++;
    if (o_pattern[0] !== 1'b0) begin
      fails++;
      $display("FAIL lane0_first_bit: got %b required 0", o_pattern[0]);
    end
    pump(4096, 0, -1, 1'b0, 5000);
    check_done_end("lfsr_burst");
  endtask

  task automatic test_ide_burst();
    sb.delete();
    push_ide(2048);
    burst_acc = 0;
    i_state = S_IDE;
    pump(2048, 0, -1, 1'b0, 2200);
    check_done_end("ide_burst");
  endtask

  task automatic test_stall();
    do_clear();
    m_reseed();
    sb.delete();
    push_lfsr(4096);
    burst_acc = 0;
    i_state = S_LFSR;
    pump(4096, 30, -1, 1'b0, 12000);
    check_done_end("stall_burst");
  endtask

  task automatic test_inject();
    do_clear();
    m_reseed();
    sb.delete();
    push_lfsr(300);
    sb[100] = sb[100] ^ 16'h0081;
    burst_acc = 0;
    i_state = S_LFSR;
    pump(300, 0, 100, 1'b0, 400);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL inject_count: %0d beats left, required 0", sb.size());
    end
    @(negedge clk);
    i_state = S_IDLE;
  endtask

  task automatic test_reentry();
    do_clear();
    m_reseed();
    sb.delete();
    push_lfsr(1000);
    burst_acc = 0;
    i_enable = 1'b1;
    i_state = S_LFSR;
    pump(1000, 0, -1, 1'b1, 1100);
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL enable_underflow: o_valid=%b required 0", o_valid);
    end
    i_state = S_IDLE;
    repeat (2) @(negedge clk);
    tests++;
    if (o_valid !== 1'b0 || o_pattern !== 16'h0000) begin
      fails++;
      $display("FAIL idle_mid_burst: valid=%b pattern=%h required 0 0000", o_valid, o_pattern);
    end
    i_enable = 1'b1;
    push_lfsr(4096);
    burst_acc = 0;
    i_state = S_LFSR;
    @(negedge clk);
    tests++;
    if (o_done !== 1'b0) begin
      fails++;
      $display("FAIL reentry_done: o_done=%b required 0", o_done);
    end
    pump(4096, 0, -1, 1'b0, 4200);
    check_done_end("reentry_burst");
    do_clear();
    m_reseed();
    sb.delete();
    push_lfsr(200);
    burst_acc = 0;
    i_state = S_LFSR;
    pump(200, 0, -1, 1'b0, 300);
    @(negedge clk);
    i_state = S_IDLE;
  endtask

  task automatic test_async_reset();
    do_clear();
    m_reseed();
    sb.delete();
    push_lfsr(4096);
    burst_acc = 0;
    i_state = S_LFSR;
    pump(50, 0, -1, 1'b0, 100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (o_valid !== 1'b0 || o_done !== 1'b0 || o_pattern !== 16'h0000) begin
      fails++;
      $display("FAIL async_reset: valid=%b done=%b pattern=%h required 0 0 0000",
               o_valid, o_done, o_pattern);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reseed();
    sb.delete();
    push_lfsr(100);
    burst_acc = 0;
    pump(100, 0, -1, 1'b0, 200);
    @(negedge clk);
    i_state = S_IDLE;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    i_state      = S_IDLE;
    i_enable     = 1'b0;
    i_ready      = 1'b0;
    i_inject_err = 16'h0000;
    test_reset();
    test_lfsr_burst();
    test_ide_burst();
    test_stall();
    test_inject();
    test_reentry();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
